// File: rtl/run_sequencer_pkg.sv
// Shared state type, field geometry and coordinate widths for the runner game.
// Imported by run_sequencer and its sub-modules.
package run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } run_state_t;

  localparam int unsigned FIELD_W = 1920;
  localparam int unsigned FIELD_H = 1080;
  localparam int unsigned ROW_W   = 11;
  localparam int unsigned COL_W   = 12;
  localparam int unsigned SCORE_W = 16;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/run_sequencer_key_debouncer.sv
// Button conditioner: 2-flop synchronizer, frame-tick-gated stability counter
// and rising-edge detect. Generic so further buttons can reuse it.
module key_debouncer #(
  parameter int unsigned STABLE_TICKS = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (STABLE_TICKS < 2) ? 1 : $clog2(STABLE_TICKS);

  logic             sync0;
  logic             sync1;
  logic [CNT_W-1:0] cnt_q;
  logic             differs;
  logic             accept;

  // press is asserted on the very tick the new level is accepted so the
  // consumer can act on that same edge.
  always_comb begin
    differs = sync1 ^ level;
    accept  = tick && differs && (cnt_q == CNT_W'(STABLE_TICKS - 1));
    press   = accept && sync1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      cnt_q <= '0;
      level <= 1'b0;
    end else begin
      sync0 <= key_raw;
      sync1 <= sync0;
      if (tick) begin
        if (!differs) begin
          cnt_q <= '0;
        end else if (accept) begin
          level <= sync1;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Frame-rate runner game controller: vsync-derived frame tick, jump physics,
// obstacle scroll and score. RUN_SEQUENCER_SPEEDUP_EN enables score-based speedup.
module run_sequencer #(
  parameter int unsigned GROUND_Y        = 800,
  parameter int unsigned FIELD_W         = run_pkg::FIELD_W,
  parameter int          JUMP_VEL        = 24,
  parameter int          GRAVITY         = 1,
  parameter int unsigned SCROLL_SPEED    = 8,
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned DEAD_FRAMES     = 120,
  parameter logic        VSYNC_ACTIVE    = 1'b0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        vsync,
  input  logic                        jump_key,
  input  logic                        collision,
  output logic                        frame_tick,
  output logic [1:0]                  state,
  output logic [run_pkg::ROW_W-1:0]   char_y,
  output logic [run_pkg::COL_W-1:0]   obstacle_x,
  output logic [run_pkg::SCORE_W-1:0] score
);

  import run_pkg::*;

  localparam logic [ROW_W-1:0] ROW_RST = ROW_W'(GROUND_Y);
  localparam logic [COL_W-1:0] COL_RST = COL_W'(FIELD_W - 1);
  localparam int unsigned      DC_W    = $clog2(DEAD_FRAMES + 1);

  run_state_t          state_q, state_d;
  logic                vs_q;
  logic                tick_q, tick_d;
  logic                coll_q, coll_d;
  logic                hit;
  logic [ROW_W-1:0]    y_q, y_d;
  logic [COL_W-1:0]    x_q, x_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic signed [7:0]   vel_q, vel_d, vel_use;
  logic                air_q, air_d, air_use;
  logic [DC_W-1:0]     dead_q, dead_d;
  logic [12:0]         y_calc;
  logic [COL_W-1:0]    speed;
  logic                key_level;
  logic                key_press;

  key_debouncer #(
    .STABLE_TICKS(DEBOUNCE_FRAMES)
  ) u_jump_key (
    .clock  (clock),
    .reset  (reset),
    .tick   (tick_q),
    .key_raw(jump_key),
    .level  (key_level),
    .press  (key_press)
  );

`ifdef RUN_SEQUENCER_SPEEDUP_EN
  localparam int unsigned SW = COL_W + 1;
  logic [SW-1:0] speed_sum;

  always_comb begin
    speed_sum = SW'(SCROLL_SPEED) + {1'b0, score_q[15:4]};
    speed     = (speed_sum > SW'(2 * SCROLL_SPEED)) ? COL_W'(2 * SCROLL_SPEED)
                                                    : speed_sum[COL_W-1:0];
  end
`else
  assign speed = COL_W'(SCROLL_SPEED);
`endif

  always_comb begin
    tick_d  = (vsync == VSYNC_ACTIVE) && (vs_q != VSYNC_ACTIVE);
    // Collision on the tick edge itself belongs to the frame being closed.
    hit     = coll_q | collision;
    coll_d  = tick_q ? 1'b0 : hit;

    state_d = state_q;
    y_d     = y_q;
    x_d     = x_q;
    score_d = score_q;
    vel_d   = vel_q;
    air_d   = air_q;
    dead_d  = dead_q;
    vel_use = vel_q;
    air_use = air_q;
    y_calc  = '0;

    case (state_q)
      ST_IDLE: begin
        if (tick_q && key_press) begin
          state_d = ST_RUN;
          score_d = '0;
        end
      end

      ST_RUN: begin
        if (tick_q) begin
          if (hit) begin
            state_d = ST_DEAD;
            dead_d  = '0;
          end else begin
            if (!air_q && key_level) begin
              vel_use = 8'(JUMP_VEL);
              air_use = 1'b1;
            end
            if (air_use) begin
              y_calc = {2'b00, y_q} - {{5{vel_use[7]}}, vel_use};
              if (y_calc[12]) y_calc = '0;
              y_d   = y_calc[ROW_W-1:0];
              vel_d = vel_use - 8'(GRAVITY);
              air_d = 1'b1;
              if (y_calc >= 13'(GROUND_Y)) begin
                y_d   = ROW_RST;
                air_d = 1'b0;
                vel_d = '0;
              end
            end
            if (x_q < speed) begin
              x_d     = COL_RST;
              score_d = sat_inc(score_q);
            end else begin
              x_d = x_q - speed;
            end
          end
        end
      end

      ST_DEAD: begin
        if (tick_q) begin
          if (dead_q >= DC_W'(DEAD_FRAMES)) begin
            if (key_press) begin
              state_d = ST_IDLE;
              y_d     = ROW_RST;
              x_d     = COL_RST;
              vel_d   = '0;
              air_d   = 1'b0;
            end
          end else begin
            dead_d = dead_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        y_d     = ROW_RST;
        x_d     = COL_RST;
        vel_d   = '0;
        air_d   = 1'b0;
      end
    endcase
  end

  // vs_q resets to the active level so a vsync already active at release
  // cannot produce a tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vs_q    <= VSYNC_ACTIVE;
      tick_q  <= 1'b0;
      coll_q  <= 1'b0;
      state_q <= ST_IDLE;
      y_q     <= ROW_RST;
      x_q     <= COL_RST;
      score_q <= '0;
      vel_q   <= '0;
      air_q   <= 1'b0;
      dead_q  <= '0;
    end else begin
      vs_q    <= vsync;
      tick_q  <= tick_d;
      coll_q  <= coll_d;
      state_q <= state_d;
      y_q     <= y_d;
      x_q     <= x_d;
      score_q <= score_d;
      vel_q   <= vel_d;
      air_q   <= air_d;
      dead_q  <= dead_d;
    end
  end

  assign frame_tick = tick_q;
  assign state      = state_q;
  assign char_y     = y_q;
  assign obstacle_x = x_q;
  assign score      = score_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: frames push expected outputs, a monitor
// pops and compares on every frame_tick.
module tb_run_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        vsync;
  logic        jump_key;
  logic        collision;
  logic        frame_tick;
  logic [1:0]  state;
  logic [10:0] char_y;
  logic [11:0] obstacle_x;
  logic [15:0] score;

  run_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .vsync     (vsync),
    .jump_key  (jump_key),
    .collision (collision),
    .frame_tick(frame_tick),
    .state     (state),
    .char_y    (char_y),
    .obstacle_x(obstacle_x),
    .score     (score)
  );

  always #5 clock = ~clock;

  typedef struct {
    int f;
    bit chk;
    int st;
    int y;
    int x;
    int sc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ticks  = 0;
  int   frames = 0;

  task automatic check(input string name, input int f, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s frame %0d got %0d expected %0d", name, f, got, want);
    end
  endtask

  // Directed expectations, hand-derived at default parameters.
  function automatic exp_t vec(input int f);
    exp_t e;
    e.f = f; e.chk = 1'b1; e.st = 0; e.y = 800; e.x = 1919; e.sc = 0;
    case (f)
      1, 2, 3, 4: ;
      5:   e.st = 1;
      6:   begin e.st = 1; e.y = 776; e.x = 1911; end
      7:   begin e.st = 1; e.y = 753; e.x = 1903; end
      29:  begin e.st = 1; e.y = 500; e.x = 1727; end
      30:  begin e.st = 1; e.y = 500; e.x = 1719; end
      31:  begin e.st = 1; e.y = 501; e.x = 1711; end
      53:  begin e.st = 1; e.y = 776; e.x = 1535; end
      54:  begin e.st = 1; e.y = 800; e.x = 1527; end
      55:  begin e.st = 1; e.y = 800; e.x = 1519; end
      244: begin e.st = 1; e.x = 7; end
      245: begin e.st = 1; e.sc = 1; end
      246, 261, 366, 369: begin e.st = 2; e.sc = 1; end
      370, 371: e.sc = 1;
      375: e.st = 1;
      376: begin e.st = 1; e.y = 776; e.x = 1911; end
      377: begin e.st = 1; e.y = 753; e.x = 1903; end
      default: e.chk = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic key_at(input int f);
    return (f >= 4 && f <= 6) || (f >= 244 && f <= 246) || (f >= 260 && f <= 261) ||
           (f >= 369 && f <= 371) || (f >= 374 && f <= 377);
  endfunction

  // One 12-cycle frame: 8 cycles vsync inactive, 4 active. Called just after a negedge.
  task automatic do_frame(input logic key, input logic coll, input exp_t e);
    frames++;
    exp_q.push_back(e);
    jump_key = key;
    vsync    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      collision = coll && (i == 3);
    end
    vsync = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clock);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (frame_tick === 1'b1) begin
        ticks++;
        @(negedge clock);
        check("tick_width", ticks, int'(frame_tick), 0);
        checks++;
        if (char_y > 11'd800) begin
          errors++;
          $display("FAIL y_bound tick %0d got %0d expected <= 800", ticks, char_y);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick tick %0d got tick expected none", ticks);
        end else begin
          e = exp_q.pop_front();
          if (e.chk) begin
            check("state", e.f, int'(state), e.st);
            check("char_y", e.f, int'(char_y), e.y);
            check("obstacle_x", e.f, int'(obstacle_x), e.x);
            check("score", e.f, int'(score), e.sc);
          end
        end
      end
    end
  end

  initial begin : stimulus
    exp_t e;
    int   ticks_before;
    reset     = 1'b1;
    vsync     = 1'b0;
    jump_key  = 1'b0;
    collision = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_state", 0, int'(state), 0);
    check("rst_char_y", 0, int'(char_y), 800);
    check("rst_obstacle_x", 0, int'(obstacle_x), 1919);
    check("rst_score", 0, int'(score), 0);
    check("rst_frame_tick", 0, int'(frame_tick), 0);
    reset = 1'b0;
    @(negedge clock);

    for (int f = 1; f <= 377; f++) begin
      e = vec(f);
      do_frame(key_at(f), f == 246, e);
    end

    // Asynchronous reset mid-jump, with vsync left active through release.
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", 378, int'(state), 0);
    check("async_rst_char_y", 378, int'(char_y), 800);
    check("async_rst_obstacle_x", 378, int'(obstacle_x), 1919);
    check("async_rst_score", 378, int'(score), 0);
    @(negedge clock);
    check("rst_next_char_y", 378, int'(char_y), 800);
    @(negedge clock);
    reset = 1'b0;
    ticks_before = ticks;
    repeat (6) @(negedge clock);
    check("no_tick_after_rst", 378, ticks, ticks_before);

    e.f = 378; e.chk = 1'b1; e.st = 0; e.y = 800; e.x = 1919; e.sc = 0;
    jump_key = 1'b0;
    do_frame(1'b0, 1'b0, e);
    repeat (4) @(negedge clock);

    check("queue_drained", 379, exp_q.size(), 0);
    check("tick_count", 379, ticks, frames);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
